// File: rtl/kong_ctrl.sv
// Kong antagonist controller: game-state FSM, tick-driven throw animation and
// barrel-spawn valid/ready handshake toward the barrel manager.
module kong_ctrl #(
   parameter int X_POS       = 150,
   parameter int Y_POS       = 150,
   parameter int ANIM_DIV    = 2,
   parameter int CYCLE_LEN   = 16,
   parameter int MAX_BARRELS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_tick,
   input  logic       start,
   input  logic       over,
   input  logic       pause,
   input  logic       spawn_ready,
   input  logic       barrel_done,
   output logic [9:0] x,
   output logic [8:0] y,
   output logic [1:0] state,
   output logic [1:0] animation_state,
   output logic       spawn_valid,
   output logic [3:0] live_barrels
);

   localparam int DIV_W  = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
   localparam int STEP_W = $clog2(CYCLE_LEN);

   localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(ANIM_DIV - 1);
   localparam logic [STEP_W-1:0] STEP_LAST  = STEP_W'(CYCLE_LEN - 1);
   localparam logic [STEP_W-1:0] GET_FIRST  = STEP_W'(CYCLE_LEN - 6);
   localparam logic [STEP_W-1:0] HOLD_FIRST = STEP_W'(CYCLE_LEN - 4);
   localparam logic [STEP_W-1:0] DROP_FIRST = STEP_W'(CYCLE_LEN - 2);
   localparam logic [3:0]        MAX_LIVE   = 4'(MAX_BARRELS);

   typedef enum logic [1:0] {
      ST_INITIAL = 2'b00,
      ST_PLAYING = 2'b01,
      ST_PAUSED  = 2'b10
   } state_e;

   typedef enum logic [1:0] {
      AN_NORMAL = 2'b00,
      AN_GET    = 2'b01,
      AN_HOLD   = 2'b10,
      AN_DROP   = 2'b11
   } anim_e;

   // The last six steps of a throw cycle are GET, HOLD, DROP (two steps each).
   function automatic anim_e anim_of(input logic [STEP_W-1:0] s);
      anim_e a;
      if (s >= DROP_FIRST) begin
         a = AN_DROP;
      end else if (s >= HOLD_FIRST) begin
         a = AN_HOLD;
      end else if (s >= GET_FIRST) begin
         a = AN_GET;
      end else begin
         a = AN_NORMAL;
      end
      return a;
   endfunction

   state_e             state_q, state_d;
   anim_e              anim_q, anim_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [STEP_W-1:0]  step_q, step_d;
   logic               spawn_q, spawn_d;
   logic [3:0]         live_q, live_d;
   logic               transfer_s;
   logic               stall_s;
   logic               done_s;

   // Next-state logic for the game FSM, animation counters, handshake and barrel count.
   always_comb begin
      transfer_s = spawn_q & spawn_ready;
      stall_s    = spawn_q & ~spawn_ready;
      done_s     = barrel_done & (live_q != 4'd0);

      state_d = state_q;
      case (state_q)
         ST_INITIAL: begin
            if (start) state_d = ST_PLAYING;
            else       state_d = ST_INITIAL;
         end
         ST_PLAYING: begin
            if (over)       state_d = ST_INITIAL;
            else if (pause) state_d = ST_PAUSED;
            else            state_d = ST_PLAYING;
         end
         ST_PAUSED: begin
            if (over)        state_d = ST_INITIAL;
            else if (!pause) state_d = ST_PLAYING;
            else             state_d = ST_PAUSED;
         end
         default: state_d = ST_INITIAL;
      endcase

      div_d  = div_q;
      step_d = step_q;
      if (transfer_s) spawn_d = 1'b0;
      else            spawn_d = spawn_q;

      // Ticks arriving while a spawn request waits for acceptance are dropped.
      if ((state_q == ST_PLAYING) && frame_tick && !stall_s) begin
         if (div_q == DIV_LAST) begin
            div_d = {DIV_W{1'b0}};
            if (step_q == STEP_LAST) step_d = {STEP_W{1'b0}};
            else                     step_d = step_q + STEP_W'(1);
            if ((step_d == DROP_FIRST) && (live_q < MAX_LIVE)) spawn_d = 1'b1;
            else                                               spawn_d = spawn_d;
         end else begin
            div_d = div_q + DIV_W'(1);
         end
      end else begin
         div_d  = div_q;
         step_d = step_q;
      end

      case ({transfer_s, done_s})
         2'b10: begin
            if (live_q < MAX_LIVE) live_d = live_q + 4'd1;
            else                   live_d = live_q;
         end
         2'b01:   live_d = live_q - 4'd1;
         default: live_d = live_q;
      endcase

      if (state_d == ST_INITIAL) begin
         div_d   = {DIV_W{1'b0}};
         step_d  = {STEP_W{1'b0}};
         spawn_d = 1'b0;
         live_d  = 4'd0;
      end else begin
         live_d = live_d;
      end

      anim_d = anim_of(step_d);
   end

   // Single state register for FSM, counters and all registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_INITIAL;
         anim_q  <= AN_NORMAL;
         div_q   <= {DIV_W{1'b0}};
         step_q  <= {STEP_W{1'b0}};
         spawn_q <= 1'b0;
         live_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         anim_q  <= anim_d;
         div_q   <= div_d;
         step_q  <= step_d;
         spawn_q <= spawn_d;
         live_q  <= live_d;
      end
   end

   assign x               = 10'(X_POS);
   assign y               = 9'(Y_POS);
   assign state           = state_q;
   assign animation_state = anim_q;
   assign spawn_valid     = spawn_q;
   assign live_barrels    = live_q;

endmodule
